// File: rtl/multicycle_control_seq.sv
// Multi-cycle control sequencer for the 9-bit ISA.
// Accepts one instruction at a time over a valid/ready handshake, holds it in ir,
// and walks DECODE -> EXEC -> (MEM -> WB) while driving the datapath control set.
// Handshake: an instruction transfers on a cycle where instr_valid and instr_ready
// are both high; instr_ready is high only in DECODE, and instr/instr_valid are
// ignored in every other cycle.
module multicycle_control_seq #(
    parameter int IW      = 9,
    parameter int MEM_LAT = 2,
    parameter int CW      = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          alu_lt,
    input  logic          alu_gt,
    input  logic          alu_eq,
    output logic          reg_write,
    output logic          mem_read,
    output logic          mem_write,
    output logic          mem_to_reg,
    output logic          alu_src,
    output logic          reg_src,
    output logic [2:0]    alu_op,
    output logic          branch_taken,
    output logic          jump,
    output logic          pc_en,
    output logic          illegal,
    output logic          halted,
    output logic [2:0]    flags,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_DECODE = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] TY_MATH   = 2'b00;
    localparam logic [1:0] TY_COND   = 2'b01;
    localparam logic [1:0] TY_ASSIGN = 2'b10;

    localparam logic [2:0] OP_LI    = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_CMP   = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [2:0]    flags_q, flags_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] ty;
    logic [2:0] sub;
    logic       is_load;
    logic       cond;
    logic       unused_ir_bits;

    assign ty             = ir_q[IW-1 -: 2];
    assign sub            = ir_q[IW-3 -: 3];
    assign is_load        = (sub == OP_LOAD);
    assign unused_ir_bits = ^ir_q[IW-6:0];

    // Branch condition from the flags held at entry to EXEC.
    always_comb begin
        cond = 1'b0;
        case (ir_q[IW-3 -: 2])
            2'b00:   cond = flags_q[2];
            2'b01:   cond = flags_q[1];
            2'b10:   cond = ~flags_q[0];
            default: cond = flags_q[0];
        endcase
    end

    // State register, instruction register, compare flags and wait counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_DECODE;
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control decode from state and ir; everything forced low in reset.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        instr_ready  = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        reg_src      = 1'b0;
        alu_op       = 3'b000;
        branch_taken = 1'b0;
        jump         = 1'b0;
        pc_en        = 1'b0;
        illegal      = 1'b0;
        halted       = 1'b0;
        flags        = flags_q;
        dbg_state    = state_q;

        case (state_q)
            S_DECODE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DECODE;
                case (ty)
                    TY_MATH: begin
                        reg_write = 1'b1;
                        alu_op    = sub;
                        pc_en     = 1'b1;
                    end
                    TY_COND: begin
                        branch_taken = cond;
                        pc_en        = 1'b1;
                    end
                    TY_ASSIGN: begin
                        case (sub)
                            OP_LI: begin
                                alu_src   = 1'b1;
                                reg_write = 1'b1;
                                pc_en     = 1'b1;
                            end
                            OP_CMP: begin
                                alu_op  = 3'b001;
                                flags_d = {alu_lt, alu_gt, alu_eq};
                                pc_en   = 1'b1;
                            end
                            OP_NOP: pc_en = 1'b1;
                            OP_HALT: state_d = S_HALT;
                            OP_LOAD, OP_STORE: begin
                                mem_read  = is_load;
                                mem_write = ~is_load;
                                if (MEM_LAT > 0) begin
                                    cnt_d   = LAT;
                                    state_d = S_MEM;
                                end else if (is_load) begin
                                    state_d = S_WB;
                                end else begin
                                    pc_en = 1'b1;
                                end
                            end
                            default: begin
                                // undefined assign sub-ops retire as a nop
                                illegal = 1'b1;
                                pc_en   = 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        if (ir_q[IW-3]) begin
                            jump  = 1'b1;
                            pc_en = 1'b1;
                        end else begin
                            reg_src   = 1'b1;
                            reg_write = 1'b1;
                            pc_en     = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                // strobe held from EXEC so its width is 1+MEM_LAT cycles
                mem_read  = is_load;
                mem_write = ~is_load;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                pc_en      = 1'b1;
                state_d    = S_DECODE;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_DECODE;
        endcase

        if (Reset) begin
            instr_ready  = 1'b0;
            reg_write    = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_to_reg   = 1'b0;
            alu_src      = 1'b0;
            reg_src      = 1'b0;
            alu_op       = 3'b000;
            branch_taken = 1'b0;
            jump         = 1'b0;
            pc_en        = 1'b0;
            illegal      = 1'b0;
            halted       = 1'b0;
            flags        = 3'b000;
            dbg_state    = 3'b000;
        end
    end

endmodule

// File: tb/tb_multicycle_control_seq.sv
// Bench for multicycle_control_seq: directed table, hand-written multi-cycle
// sequences, and random instruction streams checked against a trace model.
module tb_multicycle_control_seq;

    localparam int LAT = 2;

    typedef struct packed {
        logic       ready;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       asrc;
        logic       rsrc;
        logic [2:0] aop;
        logic       bt;
        logic       jmp;
        logic       pc;
        logic       ill;
        logic       hlt;
        logic [2:0] fl;
    } ovec_t;

    // s = {rw, mr, mw, m2r, asrc, rsrc, bt, jmp, pc, ill}; len counts the accept cycle
    typedef struct {
        logic [8:0] instr;
        logic [2:0] alu;
        logic [9:0] s;
        logic [2:0] aop;
        logic [2:0] fl;
        int         len;
    } tv_t;

    // clock / reset
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset;
    logic [8:0] instr, instr0;
    logic       instr_valid, instr_valid0;
    logic       alu_lt, alu_gt, alu_eq;

    logic       instr_ready, reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_src;
    logic [2:0] alu_op, flags, dbg_state;
    logic       branch_taken, jump, pc_en, illegal, halted;

    logic       instr_ready_z, reg_write_z, mem_read_z, mem_write_z, mem_to_reg_z;
    logic       alu_src_z, reg_src_z;
    logic [2:0] alu_op_z, flags_z, dbg_state_z;
    logic       branch_taken_z, jump_z, pc_en_z, illegal_z, halted_z;

    multicycle_control_seq #(.IW(9), .MEM_LAT(LAT), .CW(4)) dut (
        .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_eq(alu_eq),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_src(reg_src), .alu_op(alu_op),
        .branch_taken(branch_taken), .jump(jump), .pc_en(pc_en), .illegal(illegal),
        .halted(halted), .flags(flags), .dbg_state(dbg_state)
    );

    multicycle_control_seq #(.IW(9), .MEM_LAT(0), .CW(4)) dut0 (
        .Clk(Clk), .Reset(Reset), .instr(instr0), .instr_valid(instr_valid0),
        .instr_ready(instr_ready_z), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_eq(alu_eq),
        .reg_write(reg_write_z), .mem_read(mem_read_z), .mem_write(mem_write_z),
        .mem_to_reg(mem_to_reg_z), .alu_src(alu_src_z), .reg_src(reg_src_z),
        .alu_op(alu_op_z), .branch_taken(branch_taken_z), .jump(jump_z), .pc_en(pc_en_z),
        .illegal(illegal_z), .halted(halted_z), .flags(flags_z), .dbg_state(dbg_state_z)
    );

    // scoreboard state
    int          n_checks;
    int          n_fail;
    logic [17:0] exp_q[$];
    logic [2:0]  m_flags;
    tv_t         tbl[22];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic ovec_t get_out();
        ovec_t v;
        v.ready = instr_ready; v.rw = reg_write; v.mr = mem_read; v.mw = mem_write;
        v.m2r = mem_to_reg; v.asrc = alu_src; v.rsrc = reg_src; v.aop = alu_op;
        v.bt = branch_taken; v.jmp = jump; v.pc = pc_en; v.ill = illegal;
        v.hlt = halted; v.fl = flags;
        return v;
    endfunction

    function automatic ovec_t get_out_z();
        ovec_t v;
        v.ready = instr_ready_z; v.rw = reg_write_z; v.mr = mem_read_z; v.mw = mem_write_z;
        v.m2r = mem_to_reg_z; v.asrc = alu_src_z; v.rsrc = reg_src_z; v.aop = alu_op_z;
        v.bt = branch_taken_z; v.jmp = jump_z; v.pc = pc_en_z; v.ill = illegal_z;
        v.hlt = halted_z; v.fl = flags_z;
        return v;
    endfunction

    function automatic ovec_t mk(input logic [9:0] s, input logic [2:0] aop,
                                 input logic [2:0] fl);
        ovec_t v;
        v = '0;
        {v.rw, v.mr, v.mw, v.m2r, v.asrc, v.rsrc, v.bt, v.jmp, v.pc, v.ill} = s;
        v.aop = aop;
        v.fl  = fl;
        return v;
    endfunction

    function automatic ovec_t ready_vec(input logic [2:0] fl);
        ovec_t v;
        v = '0;
        v.ready = 1'b1;
        v.fl    = fl;
        return v;
    endfunction

    task automatic check_vec(input string name, input ovec_t act, input ovec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-cycle expected outputs from the accept cycle to retirement.
    task automatic model_trace(input logic [8:0] ins, input logic [2:0] alu);
        ovec_t e, v;
        logic  c;
        exp_q.delete();
        exp_q.push_back(ready_vec(m_flags));
        e    = '0;
        e.fl = m_flags;
        case (ins[8:7])
            2'b00: begin
                e.rw = 1; e.aop = ins[6:4]; e.pc = 1;
                exp_q.push_back(e);
            end
            2'b01: begin
                case (ins[6:5])
                    2'b00:   c = m_flags[2];
                    2'b01:   c = m_flags[1];
                    2'b10:   c = ~m_flags[0];
                    default: c = m_flags[0];
                endcase
                e.bt = c; e.pc = 1;
                exp_q.push_back(e);
            end
            2'b10: begin
                case (ins[6:4])
                    3'b000: begin
                        e.asrc = 1; e.rw = 1; e.pc = 1;
                        exp_q.push_back(e);
                    end
                    3'b100: begin
                        e.aop = 3'b001; e.pc = 1;
                        exp_q.push_back(e);
                        m_flags = alu;
                    end
                    3'b101: begin
                        e.pc = 1;
                        exp_q.push_back(e);
                    end
                    3'b111: exp_q.push_back(e);
                    3'b010, 3'b011: begin
                        for (int k = 0; k <= LAT; k++) begin
                            v = e;
                            if (ins[4] == 1'b0) begin
                                v.mr = 1;
                            end else begin
                                v.mw = 1;
                                v.pc = (k == LAT);
                            end
                            exp_q.push_back(v);
                        end
                        if (ins[4] == 1'b0) begin
                            v = e; v.rw = 1; v.m2r = 1; v.pc = 1;
                            exp_q.push_back(v);
                        end
                    end
                    default: begin
                        e.ill = 1; e.pc = 1;
                        exp_q.push_back(e);
                    end
                endcase
            end
            default: begin
                if (ins[6]) begin
                    e.jmp = 1; e.pc = 1;
                end else begin
                    e.rsrc = 1; e.rw = 1; e.pc = 1;
                end
                exp_q.push_back(e);
            end
        endcase
    endtask

    // Driver: present one instruction in DECODE, scramble inputs while it executes.
    task automatic run_instr(input logic [8:0] ins, input logic [2:0] alu);
        ovec_t e;
        model_trace(ins, alu);
        {alu_lt, alu_gt, alu_eq} = alu;
        instr       = ins;
        instr_valid = 1'b1;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check_vec("rand_trace", get_out(), e);
            tick();
            instr       = 9'($urandom);
            instr_valid = 1'($urandom_range(0, 1));
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        logic [8:0] ins;
        logic [2:0] alu;

        n_checks = 0;
        n_fail   = 0;
        m_flags  = 3'b000;

        tbl[0]  = '{9'b000000101, 3'b000, 10'b1000000010, 3'b000, 3'b000, 2};
        tbl[1]  = '{9'b000010011, 3'b000, 10'b1000000010, 3'b001, 3'b000, 2};
        tbl[2]  = '{9'b001101111, 3'b000, 10'b1000000010, 3'b110, 3'b000, 2};
        tbl[3]  = '{9'b101000000, 3'b100, 10'b0000000010, 3'b001, 3'b000, 2};
        tbl[4]  = '{9'b010000000, 3'b000, 10'b0000001010, 3'b000, 3'b100, 2};
        tbl[5]  = '{9'b011100000, 3'b000, 10'b0000000010, 3'b000, 3'b100, 2};
        tbl[6]  = '{9'b010100000, 3'b000, 10'b0000000010, 3'b000, 3'b100, 2};
        tbl[7]  = '{9'b011000000, 3'b000, 10'b0000001010, 3'b000, 3'b100, 2};
        tbl[8]  = '{9'b101000000, 3'b011, 10'b0000000010, 3'b001, 3'b100, 2};
        tbl[9]  = '{9'b010100000, 3'b000, 10'b0000001010, 3'b000, 3'b011, 2};
        tbl[10] = '{9'b011000000, 3'b000, 10'b0000000010, 3'b000, 3'b011, 2};
        tbl[11] = '{9'b010000000, 3'b000, 10'b0000000010, 3'b000, 3'b011, 2};
        tbl[12] = '{9'b011100000, 3'b000, 10'b0000001010, 3'b000, 3'b011, 2};
        tbl[13] = '{9'b100000111, 3'b000, 10'b1000100010, 3'b000, 3'b011, 2};
        tbl[14] = '{9'b101010000, 3'b000, 10'b0000000010, 3'b000, 3'b011, 2};
        tbl[15] = '{9'b100010000, 3'b000, 10'b0000000011, 3'b000, 3'b011, 2};
        tbl[16] = '{9'b101100000, 3'b000, 10'b0000000011, 3'b000, 3'b011, 2};
        tbl[17] = '{9'b110101010, 3'b000, 10'b1000010010, 3'b000, 3'b011, 2};
        tbl[18] = '{9'b111000000, 3'b000, 10'b0000000110, 3'b000, 3'b011, 2};
        tbl[19] = '{9'b101000000, 3'b001, 10'b0000000010, 3'b001, 3'b011, 2};
        tbl[20] = '{9'b100100000, 3'b000, 10'b0100000000, 3'b000, 3'b001, 5};
        tbl[21] = '{9'b100110000, 3'b000, 10'b0010000000, 3'b000, 3'b001, 4};

        // reset held 3 cycles with an add already presented
        Reset        = 1'b1;
        instr        = 9'b000000101;
        instr_valid  = 1'b1;
        {alu_lt, alu_gt, alu_eq} = 3'b000;
        instr0       = '0;
        instr_valid0 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_vec("reset_outputs", get_out(), '0);
            tick();
        end
        Reset = 1'b0;

        // directed table
        for (int i = 0; i < 22; i++) begin
            instr       = tbl[i].instr;
            instr_valid = 1'b1;
            {alu_lt, alu_gt, alu_eq} = tbl[i].alu;
            #1;
            check_vec($sformatf("tbl_accept[%0d]", i), get_out(), ready_vec(tbl[i].fl));
            tick();
            instr_valid = 1'b0;
            instr       = 9'($urandom);
            #1;
            check_vec($sformatf("tbl_exec[%0d]", i), get_out(),
                      mk(tbl[i].s, tbl[i].aop, tbl[i].fl));
            tick();
            n = 2;
            while (instr_ready !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            check_int($sformatf("tbl_latency[%0d]", i), n, tbl[i].len);
        end
        m_flags = 3'b001;

        // load: mem_read width, then write-back
        instr       = 9'b100100000;
        instr_valid = 1'b1;
        #1;
        check_vec("load_accept", get_out(), ready_vec(m_flags));
        tick();
        instr_valid = 1'b0;
        n = 0;
        while (mem_read === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        check_int("load_strobe_width", n, 1 + LAT);
        check_vec("load_wb", get_out(), mk(10'b1001000010, 3'b000, m_flags));
        tick();
        check_vec("load_done", get_out(), ready_vec(m_flags));

        // reset in the middle of a load's MEM phase
        instr       = 9'b100100000;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check_vec("reset_mid_mem", get_out(), '0);
        tick();
        Reset = 1'b0;
        #1;
        check_vec("after_reset_mid_mem", get_out(), ready_vec(3'b000));
        check_int("after_reset_state", int'(dbg_state), 0);
        m_flags = 3'b000;
        tick();

        // zero-latency build: store retires in EXEC, load goes straight to WB
        instr0       = 9'b100110000;
        instr_valid0 = 1'b1;
        #1;
        check_vec("z_store_accept", get_out_z(), ready_vec(3'b000));
        tick();
        instr_valid0 = 1'b0;
        #1;
        check_vec("z_store_exec", get_out_z(), mk(10'b0010000010, 3'b000, 3'b000));
        tick();
        instr0       = 9'b100100000;
        instr_valid0 = 1'b1;
        #1;
        check_vec("z_store_done", get_out_z(), ready_vec(3'b000));
        tick();
        instr_valid0 = 1'b0;
        #1;
        check_vec("z_load_exec", get_out_z(), mk(10'b0100000000, 3'b000, 3'b000));
        tick();
        #1;
        check_vec("z_load_wb", get_out_z(), mk(10'b1001000010, 3'b000, 3'b000));
        tick();
        #1;
        check_vec("z_load_done", get_out_z(), ready_vec(3'b000));

        // random instruction stream (halt excluded)
        for (int i = 0; i < 300; i++) begin
            ins = 9'($urandom_range(0, 511));
            if (ins[8:4] == 5'b10111) ins[8:4] = 5'b10101;
            alu = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                instr       = 9'($urandom);
                #1;
                check_vec("idle_decode", get_out(), ready_vec(m_flags));
                tick();
            end
            run_instr(ins, alu);
        end

        // illegal then halt, held against a stream of valid instructions
        run_instr(9'b100010000, 3'b000);
        instr       = 9'b101110000;
        instr_valid = 1'b1;
        #1;
        check_vec("halt_accept", get_out(), ready_vec(m_flags));
        tick();
        #1;
        check_vec("halt_exec", get_out(), mk(10'b0, 3'b000, m_flags));
        tick();
        for (int i = 0; i < 20; i++) begin
            instr       = 9'($urandom);
            instr_valid = 1'b1;
            #1;
            check_vec("halted_hold", get_out(), 18'h00008 | 18'(m_flags));
            tick();
        end
        Reset = 1'b1;
        #1;
        check_vec("halt_reset", get_out(), '0);
        tick();
        Reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check_vec("halt_recover", get_out(), ready_vec(3'b000));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
